feedback_notch_scheduler: RTL and testbench

- Allocates a small bank of notch-filter slots in the feedback suppressor to the howl frequencies reported by the detector.
- Refreshes a slot when its frequency is detected again.
- Ages slots out per sample and evicts round-robin when the bank is full.
- Issues enable/disable configuration writes to the notch bank over a valid/ready handshake. Sits between the howl detector and the notch datapath.

---
 rtl/feedback_notch_scheduler.sv | 138 +++++++++++++
 tb/tb_feedback_notch_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/feedback_notch_scheduler.sv
// feedback_notch_scheduler: allocates, refreshes, ages and evicts notch slots for detected howl bins.
// Optional FEEDBACK_NOTCH_SCHED_STATS_EN adds a saturating eviction counter output.
module feedback_notch_scheduler #(
  parameter int NSLOTS = 4,
  parameter int BIN_W = 8,
  parameter int HOLD_W = 16,
  parameter int HOLD_INIT = 48000,
  localparam int SLOT_W = $clog2(NSLOTS)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ce_sample,
  input  logic              i_det_valid,
  input  logic [BIN_W-1:0]  i_det_bin,
  output logic              o_det_ready,
  output logic              o_cfg_valid,
  input  logic              i_cfg_ready,
  output logic [SLOT_W-1:0] o_cfg_slot,
  output logic [BIN_W-1:0]  o_cfg_bin,
  output logic              o_cfg_en,
  output logic [NSLOTS-1:0] o_active,
  output logic              o_busy
`ifdef FEEDBACK_NOTCH_SCHED_STATS_EN
  ,
  output logic [15:0]       o_evict_count
`endif
);
  typedef enum logic [1:0] {IDLE, MATCH, ISSUE} state_e;
  state_e state_q, state_d;
  logic [NSLOTS-1:0] active_q, exp_q;
  logic [BIN_W-1:0] bin_q [NSLOTS];
  logic [HOLD_W-1:0] hold_q [NSLOTS];
  logic [SLOT_W-1:0] victim_q, cfg_slot_q, cfg_slot_d, tgt_d, hit_idx, free_idx, exp_idx;
  logic [BIN_W-1:0] lat_bin_q, cfg_bin_q, cfg_bin_d;
  logic cfg_en_q, cfg_en_d, hit, free_ok, exp_any, accept, reload, evict;
  always_comb begin
    hit = 1'b0;
    free_ok = 1'b0;
    exp_any = 1'b0;
    hit_idx = '0;
    free_idx = '0;
    exp_idx = '0;
    for (int s = NSLOTS - 1; s >= 0; s--) begin
      if (active_q[s] && bin_q[s] == lat_bin_q) begin hit = 1'b1; hit_idx = SLOT_W'(s); end
      if (!active_q[s]) begin free_ok = 1'b1; free_idx = SLOT_W'(s); end
      if (exp_q[s]) begin exp_any = 1'b1; exp_idx = SLOT_W'(s); end
    end
  end
  always_comb begin
    state_d = state_q;
    cfg_slot_d = cfg_slot_q;
    cfg_bin_d = cfg_bin_q;
    cfg_en_d = cfg_en_q;
    accept = 1'b0;
    reload = 1'b0;
    evict = 1'b0;
    tgt_d = hit ? hit_idx : free_ok ? free_idx : victim_q;
    case (state_q)
      IDLE: begin
        if (exp_any) begin
          cfg_slot_d = exp_idx;
          cfg_bin_d = bin_q[exp_idx];
          cfg_en_d = 1'b0;
          state_d = ISSUE;
        end else if (i_det_valid) begin
          accept = 1'b1;
          state_d = MATCH;
        end
      end
      MATCH: begin
        reload = 1'b1;
        evict = !hit && !free_ok;
        cfg_slot_d = tgt_d;
        cfg_bin_d = lat_bin_q;
        cfg_en_d = 1'b1;
        state_d = hit ? IDLE : ISSUE;
      end
      ISSUE: state_d = i_cfg_ready ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      active_q <= '0;
      exp_q <= '0;
      victim_q <= '0;
      lat_bin_q <= '0;
      cfg_slot_q <= '0;
      cfg_bin_q <= '0;
      cfg_en_q <= 1'b0;
      for (int s = 0; s < NSLOTS; s++) begin
        bin_q[s] <= '0;
        hold_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      cfg_slot_q <= cfg_slot_d;
      cfg_bin_q <= cfg_bin_d;
      cfg_en_q <= cfg_en_d;
      if (accept) lat_bin_q <= i_det_bin;
      if (evict) victim_q <= victim_q + 1'b1;
      for (int s = 0; s < NSLOTS; s++) begin
        // a MATCH reload wins over same-cycle aging of that slot
        if (reload && tgt_d == SLOT_W'(s)) begin
          active_q[s] <= 1'b1;
          bin_q[s] <= lat_bin_q;
          hold_q[s] <= HOLD_W'(HOLD_INIT);
          exp_q[s] <= 1'b0;
        end else begin
          if (i_ce_sample && active_q[s] && hold_q[s] != '0) begin
            hold_q[s] <= hold_q[s] - 1'b1;
            if (hold_q[s] == HOLD_W'(1)) exp_q[s] <= 1'b1;
          end
          if (state_q == ISSUE && i_cfg_ready && !cfg_en_q && cfg_slot_q == SLOT_W'(s)) begin
            active_q[s] <= 1'b0;
            exp_q[s] <= 1'b0;
          end
        end
      end
    end
  end
`ifdef FEEDBACK_NOTCH_SCHED_STATS_EN
  logic [15:0] evict_cnt_q;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) evict_cnt_q <= '0;
    else if (evict && evict_cnt_q != 16'hFFFF) evict_cnt_q <= evict_cnt_q + 16'd1;
  end
  assign o_evict_count = evict_cnt_q;
`endif
  assign o_det_ready = state_q == IDLE && !exp_any && !i_reset;
  assign o_cfg_valid = state_q == ISSUE;
  assign o_busy = state_q != IDLE;
  assign o_cfg_slot = cfg_slot_q;
  assign o_cfg_bin = cfg_bin_q;
  assign o_cfg_en = cfg_en_q;
  assign o_active = active_q;
endmodule

// File: tb/tb_feedback_notch_scheduler.sv
// tb_feedback_notch_scheduler: directed scenarios plus randomized run against a slot-bank model.
module tb_feedback_notch_scheduler;
  localparam int NS = 4;
  localparam int HI = 3;
  logic clk = 1'b0, rst = 1'b1, ce = 1'b0, det_valid = 1'b0, cfg_ready = 1'b0;
  logic [7:0] det_bin = '0;
  logic det_ready, cfg_valid, cfg_en, busy;
  logic [1:0] cfg_slot;
  logic [7:0] cfg_bin;
  logic [3:0] active;
`ifdef FEEDBACK_NOTCH_SCHED_STATS_EN
  logic [15:0] evict_count;
`endif
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;

  feedback_notch_scheduler #(.NSLOTS(NS), .BIN_W(8), .HOLD_W(16), .HOLD_INIT(HI)) dut (
    .i_clk(clk), .i_reset(rst), .i_ce_sample(ce), .i_det_valid(det_valid), .i_det_bin(det_bin),
    .o_det_ready(det_ready), .o_cfg_valid(cfg_valid), .i_cfg_ready(cfg_ready), .o_cfg_slot(cfg_slot),
    .o_cfg_bin(cfg_bin), .o_cfg_en(cfg_en), .o_active(active), .o_busy(busy)
`ifdef FEEDBACK_NOTCH_SCHED_STATS_EN
    , .o_evict_count(evict_count)
`endif
  );

  task automatic send(input logic [7:0] b);
    det_valid = 1'b1;
    det_bin = b;
    @(negedge clk);
    det_valid = 1'b0;
  endtask

  task automatic hs();
    cfg_ready = 1'b1;
    @(negedge clk);
    cfg_ready = 1'b0;
  endtask

  task automatic wait_cfg(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cfg_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cfg_valid, busy, det_ready, active, cfg_slot, cfg_bin, cfg_en} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0", {cfg_valid, busy, det_ready, active, cfg_slot, cfg_bin, cfg_en});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (det_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", det_ready); end
  endtask

  task automatic test_allocate();
    cfg_ready = 1'b1;
    send(8'h20);
    n_cmp++;
    if ({cfg_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL alloc_match got %b want 01", {cfg_valid, busy}); end
    @(negedge clk);
    n_cmp++;
    if ({cfg_valid, cfg_slot, cfg_bin, cfg_en} !== {1'b1, 2'd0, 8'h20, 1'b1}) begin
      n_fail++;
      $display("FAIL alloc_write got %h want %h", {cfg_valid, cfg_slot, cfg_bin, cfg_en}, {1'b1, 2'd0, 8'h20, 1'b1});
    end
    @(negedge clk);
    cfg_ready = 1'b0;
    n_cmp++;
    if ({cfg_valid, active} !== 5'b00001) begin n_fail++; $display("FAIL alloc_active got %b want 00001", {cfg_valid, active}); end
  endtask

  task automatic test_refresh();
    ce = 1'b1; @(negedge clk); ce = 1'b0;
    send(8'h20);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL refresh_busy1 got %b want 1", busy); end
    @(negedge clk);
    n_cmp++;
    if ({busy, cfg_valid} !== 2'b00) begin n_fail++; $display("FAIL refresh_done got %b want 00", {busy, cfg_valid}); end
    repeat (2) begin ce = 1'b1; @(negedge clk); ce = 1'b0; @(negedge clk); end
    n_cmp++;
    if ({cfg_valid, det_ready} !== 2'b01) begin n_fail++; $display("FAIL refresh_reload got %b want 01", {cfg_valid, det_ready}); end
  endtask

  task automatic test_expire();
    ce = 1'b1; @(negedge clk); ce = 1'b0;
    det_valid = 1'b1;
    det_bin = 8'h55;
    n_cmp++;
    if (det_ready !== 1'b0) begin n_fail++; $display("FAIL expire_ready got %b want 0", det_ready); end
    @(negedge clk);
    n_cmp++;
    if ({cfg_valid, cfg_slot, cfg_bin, cfg_en, det_ready} !== {1'b1, 2'd0, 8'h20, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL expire_write got %h want %h", {cfg_valid, cfg_slot, cfg_bin, cfg_en, det_ready}, {1'b1, 2'd0, 8'h20, 1'b0, 1'b0});
    end
    hs();
    det_valid = 1'b0;
    n_cmp++;
    if ({active, cfg_valid, busy} !== 6'd0) begin n_fail++; $display("FAIL expire_release got %b want 0", {active, cfg_valid, busy}); end
  endtask

  task automatic test_backpressure();
    send(8'h30);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({cfg_valid, cfg_slot, cfg_bin, cfg_en, det_ready} !== {1'b1, 2'd0, 8'h30, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_stall%0d got %h want %h", i, {cfg_valid, cfg_slot, cfg_bin, cfg_en, det_ready}, {1'b1, 2'd0, 8'h30, 1'b1, 1'b0});
      end
      @(negedge clk);
    end
    hs();
    n_cmp++;
    if ({cfg_valid, busy, active} !== 6'b000001) begin n_fail++; $display("FAIL bp_done got %b want 000001", {cfg_valid, busy, active}); end
  endtask

  task automatic test_evict();
    bit ok;
    logic [7:0] b;
    logic [1:0] want_slot;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      b = (i < 4) ? 8'(8'h10 + i) : 8'(8'h40 + i - 4);
      want_slot = (i < 4) ? 2'(i) : 2'(i - 4);
      send(b);
      wait_cfg(ok);
      n_cmp++;
      if (!ok || {cfg_slot, cfg_bin, cfg_en} !== {want_slot, b, 1'b1}) begin
        n_fail++;
        $display("FAIL evict_write%0d got %b/%h want %h", i, ok, {cfg_slot, cfg_bin, cfg_en}, {want_slot, b, 1'b1});
      end
      hs();
    end
    n_cmp++;
    if (active !== 4'b1111) begin n_fail++; $display("FAIL evict_active got %b want 1111", active); end
`ifdef FEEDBACK_NOTCH_SCHED_STATS_EN
    n_cmp++;
    if (evict_count !== 16'd2) begin n_fail++; $display("FAIL evict_count got %0d want 2", evict_count); end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    send(8'h50);
    wait_cfg(ok);
    n_cmp++;
    if (!ok || {cfg_slot, cfg_en} !== 3'b101) begin n_fail++; $display("FAIL rmid_issue got %b/%b want 1/101", ok, {cfg_slot, cfg_en}); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({cfg_valid, active, busy} !== 6'd0) begin n_fail++; $display("FAIL rmid_async got %b want 0", {cfg_valid, active, busy}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(8'h60);
    wait_cfg(ok);
    n_cmp++;
    if (!ok || {cfg_slot, cfg_bin, cfg_en} !== {2'd0, 8'h60, 1'b1}) begin
      n_fail++;
      $display("FAIL rmid_realloc got %b/%h want %h", ok, {cfg_slot, cfg_bin, cfg_en}, {2'd0, 8'h60, 1'b1});
    end
    hs();
  endtask

  task automatic test_random();
    logic [3:0] m_act;
    logic [7:0] m_bin [NS];
    int m_hold [NS];
    int m_vic, hit, free, t;
    logic [7:0] b;
    logic [10:0] e;
    logic [10:0] expq [$];
    bit ok;
    do_reset();
    m_act = '0;
    m_vic = 0;
    for (int s = 0; s < NS; s++) begin m_bin[s] = '0; m_hold[s] = 0; end
    for (int op = 0; op < 200; op++) begin
      if ($urandom_range(1, 0) == 1) begin
        b = 8'($urandom_range(7, 0));
        hit = -1;
        free = -1;
        for (int s = NS - 1; s >= 0; s--) begin
          if (m_act[s] && m_bin[s] == b) hit = s;
          if (!m_act[s]) free = s;
        end
        if (hit >= 0) m_hold[hit] = HI;
        else begin
          t = (free >= 0) ? free : m_vic;
          if (free < 0) m_vic = (m_vic + 1) % NS;
          m_act[t] = 1'b1;
          m_bin[t] = b;
          m_hold[t] = HI;
          expq.push_back({2'(t), b, 1'b1});
        end
        n_cmp++;
        if (det_ready !== 1'b1) begin n_fail++; $display("FAIL rand_ready op%0d got %b want 1", op, det_ready); end
        send(b);
      end else begin
        for (int s = 0; s < NS; s++)
          if (m_act[s] && m_hold[s] > 0) begin
            m_hold[s]--;
            if (m_hold[s] == 0) expq.push_back({2'(s), m_bin[s], 1'b0});
          end
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
      end
      while (expq.size() > 0) begin
        e = expq.pop_front();
        wait_cfg(ok);
        n_cmp++;
        if (!ok || {cfg_slot, cfg_bin, cfg_en} !== e) begin
          n_fail++;
          $display("FAIL rand_write op%0d got %b/%h want %h", op, ok, {cfg_slot, cfg_bin, cfg_en}, e);
        end
        repeat ($urandom_range(3, 0)) @(negedge clk);
        hs();
        if (!e[0]) m_act[e[10:9]] = 1'b0;
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy, cfg_valid, active} !== {2'b00, m_act}) begin
        n_fail++;
        $display("FAIL rand_state op%0d got %b want %b", op, {busy, cfg_valid, active}, {2'b00, m_act});
      end
    end
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_refresh();
    test_expire();
    test_backpressure();
    test_evict();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
